// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte-stream loader that writes instruction memory and gates core reset
//
// Accepts a byte stream over a valid/ready handshake, assembles little-endian
// 32-bit words and writes them sequentially into instruction memory. The core
// is held in reset until a frame with a correct checksum has been written.
//
// Frame: CNT_LO, CNT_HI, 4*N data bytes, CHK (XOR of all preceding frame bytes).
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   in_valid  in   byte on in_data is valid
//   in_data   in   [7:0] stream byte
//   in_ready  out  loader accepts a byte this cycle
//   restart   in   one-cycle pulse, re-arms the loader from DONE or ERR
//   im_we     out  instruction-memory write enable, one pulse per word
//   im_addr   out  [31:0] byte address of the write
//   im_wdata  out  [31:0] word to write
//   core_rst  out  core reset, low only in DONE
//   done      out  frame loaded with good checksum
//   error     out  frame rejected

module program_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        restart,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        core_rst,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        DONE,
        ERR
    } state_t;

    localparam logic [16:0] MAX_W = MAX_WORDS[16:0];

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] word_cnt;
    logic [1:0]  byte_idx;
    logic [31:0] word_sr;
    logic [7:0]  chk;
    logic        xfer;
    logic [15:0] cnt_next;
    logic [31:0] word_next;

    assign in_ready  = (state == LEN_LO) || (state == LEN_HI) ||
                       (state == DATA)   || (state == CHECK);
    assign xfer      = in_valid && in_ready;
    assign cnt_next  = {in_data, cnt[7:0]};
    // Bytes shift in from the top so the first byte of a word ends up in [7:0].
    assign word_next = {in_data, word_sr[31:8]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LEN_LO;
            im_we    <= 1'b0;
            im_addr  <= BASE_ADDR;
            im_wdata <= 32'd0;
            core_rst <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            chk      <= 8'd0;
            byte_idx <= 2'd0;
            word_cnt <= 16'd0;
            cnt      <= 16'd0;
            word_sr  <= 32'd0;
        end else begin
            im_we <= 1'b0;

            // The address advances after the cycle in which the write is presented,
            // so a write pulse always shows the address of its own word.
            if (im_we) begin
                im_addr <= im_addr + 32'd4;
            end

            // The checksum byte itself is excluded from the running XOR.
            if (xfer && state != CHECK) begin
                chk <= chk ^ in_data;
            end

            case (state)
                LEN_LO: begin
                    if (xfer) begin
                        cnt[7:0] <= in_data;
                        state    <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        cnt[15:8] <= in_data;
                        if ({1'b0, cnt_next} > MAX_W) begin
                            state <= ERR;
                            error <= 1'b1;
                        end else if (cnt_next == 16'd0) begin
                            state <= CHECK;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        word_sr  <= word_next;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            im_we    <= 1'b1;
                            im_wdata <= word_next;
                            word_cnt <= word_cnt + 16'd1;
                            if (word_cnt == cnt - 16'd1) begin
                                state <= CHECK;
                            end
                        end
                    end
                end
                CHECK: begin
                    if (xfer) begin
                        if (in_data == chk) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            core_rst <= 1'b0;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
                DONE, ERR: begin
                    if (restart) begin
                        state    <= LEN_LO;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        core_rst <= 1'b1;
                        chk      <= 8'd0;
                        byte_idx <= 2'd0;
                        word_cnt <= 16'd0;
                        cnt      <= 16'd0;
                        im_addr  <= BASE_ADDR;
                    end
                end
                default: begin
                    state <= LEN_LO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard testbench for program_loader

module tb_program_loader;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        restart;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        core_rst;
    logic        done;
    logic        error;

    int checks;
    int errors;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    program_loader #(
        .BASE_ADDR(32'h0000_0000),
        .MAX_WORDS(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .restart  (restart),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .core_rst (core_rst),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Write monitor: every im_we cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            if (exp_addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected", im_addr, im_wdata);
            end else begin
                check("write_addr", im_addr, exp_addr_q.pop_front());
                check("write_data", im_wdata, exp_data_q.pop_front());
            end
        end
    end

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    // Presents a byte from a falling edge; it transfers on the next rising edge
    // at which in_ready is high.
    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck at 0 for byte 0x%02h", b);
            in_valid = 1'b0;
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] bytes[$], input bit gapped);
        for (int i = 0; i < bytes.size(); i++) begin
            if (gapped) idle($urandom_range(0, 3));
            send_byte(bytes[i]);
        end
        idle(1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int n;
        n = 0;
        while (!(done || error) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!(done || error)) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: done=%0b error=%0b after 20 cycles", name, done, error);
        end
    endtask

    task automatic check_final(input string name, input logic e_done, input logic e_err);
        check({name, "_done"}, {31'd0, done}, {31'd0, e_done});
        check({name, "_error"}, {31'd0, error}, {31'd0, e_err});
        check({name, "_core_rst"}, {31'd0, core_rst}, {31'd0, ~e_done});
        check({name, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({name, "_pending"}, exp_addr_q.size(), 32'd0);
    endtask

    logic [7:0] two_word[$];
    logic [7:0] two_bad[$];
    logic [7:0] zero_cnt[$];
    logic [7:0] one_word[$];

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        restart  = 1'b0;

        // 02^00^93^00^50^00^13^01^10^00 = C3
        two_word = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                     8'h13, 8'h01, 8'h10, 8'h00, 8'hC3};
        two_bad  = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                     8'h13, 8'h01, 8'h10, 8'h00, 8'hC2};
        zero_cnt = '{8'h00, 8'h00, 8'h00};
        // 01^00^78^56^34^12 = 09
        one_word = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};

        // Reset state
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_core_rst", {31'd0, core_rst}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_im_we", {31'd0, im_we}, 32'd0);
        check("rst_im_addr", im_addr, 32'h0);
        check("rst_im_wdata", im_wdata, 32'h0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Two-word load
        expect_write(32'h0, 32'h0050_0093);
        expect_write(32'h4, 32'h0010_0113);
        send_frame(two_word, 1'b0);
        wait_end("load2");
        check_final("load2", 1'b1, 1'b0);

        // Bad checksum: writes still land, frame rejected
        do_reset();
        expect_write(32'h0, 32'h0050_0093);
        expect_write(32'h4, 32'h0010_0113);
        send_frame(two_bad, 1'b0);
        wait_end("badchk");
        check_final("badchk", 1'b0, 1'b1);

        // Zero count
        do_reset();
        send_frame(zero_cnt, 1'b0);
        wait_end("zero");
        check_final("zero", 1'b1, 1'b0);

        // Count above MAX_WORDS=4 rejected right after the count bytes
        do_reset();
        send_byte(8'h05);
        send_byte(8'h00);
        idle(1);
        check("over_error", {31'd0, error}, 32'd1);
        check("over_done", {31'd0, done}, 32'd0);
        check("over_in_ready", {31'd0, in_ready}, 32'd0);
        idle(3);
        check_final("over", 1'b0, 1'b1);

        // Gapped stream
        do_reset();
        expect_write(32'h0, 32'h0050_0093);
        expect_write(32'h4, 32'h0010_0113);
        send_frame(two_word, 1'b1);
        wait_end("gapped");
        check_final("gapped", 1'b1, 1'b0);

        // rst after 6 bytes: first word's write is already in flight
        do_reset();
        expect_write(32'h0, 32'h0050_0093);
        for (int i = 0; i < 6; i++) send_byte(two_word[i]);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_im_addr", im_addr, 32'h0);
        expect_write(32'h0, 32'h0050_0093);
        expect_write(32'h4, 32'h0010_0113);
        send_frame(two_word, 1'b0);
        wait_end("abort");
        check_final("abort", 1'b1, 1'b0);
        check("abort_addr_after", im_addr, 32'h8);

        // restart from DONE, then a one-word frame
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("restart_core_rst", {31'd0, core_rst}, 32'd1);
        check("restart_done", {31'd0, done}, 32'd0);
        check("restart_im_addr", im_addr, 32'h0);
        check("restart_in_ready", {31'd0, in_ready}, 32'd1);
        expect_write(32'h0, 32'h1234_5678);
        send_frame(one_word, 1'b0);
        wait_end("reload");
        check_final("reload", 1'b1, 1'b0);

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
